// File: rtl/store_slot_layout_if.sv
// store_slot_layout_if
//   Handshake and read-port bundle between the config parser / slot decoder
//   and store_slot_layout.
//   Parameter MAX_CONFIG sets the config index width used in rd_entry.
//   Signals:
//     update_request  parser -> layout   level, held until acked
//     update_ack      layout -> parser   one-cycle accept pulse
//     layout_valid    layout -> decoder  table complete and coherent
//     layout_done     layout -> decoder  one-cycle build-finished pulse
//     slot_expanded   layout -> decoder  per-primary-slot expansion flags
//     rd_slot/rd_sub/rd_page  decoder -> layout  read address
//     rd_entry        layout -> decoder  registered {valid, cfg_idx, page_offset}
//   Modports: master (parser/decoder side), slave (layout builder).
interface store_slot_layout_if #(
  parameter int MAX_CONFIG = 16
) ();
  localparam int CW = $clog2(MAX_CONFIG);

  logic          update_request;
  logic          update_ack;
  logic          layout_valid;
  logic          layout_done;
  logic [3:0]    slot_expanded;
  logic [1:0]    rd_slot;
  logic [1:0]    rd_sub;
  logic [1:0]    rd_page;
  logic [CW+2:0] rd_entry;

  modport master (
    output update_request, rd_slot, rd_sub, rd_page,
    input  update_ack, layout_valid, layout_done, slot_expanded, rd_entry
  );

  modport slave (
    input  update_request, rd_slot, rd_sub, rd_page,
    output update_ack, layout_valid, layout_done, slot_expanded, rd_entry
  );
endinterface

// File: rtl/store_slot_layout.sv
// store_slot_layout
//   Builds the 64-entry MSX slot layout table ({slot, sub_slot, page}) from
//   the parsed config records whenever the parser requests an update, and
//   serves it to the slot decoder through a registered read port.
//   Ports:
//     clk, reset   clock, synchronous active-high reset
//     msx_config   parsed config records (stable from ack to layout_done)
//     bus          store_slot_layout_if.slave: request/ack, status, read port
//     conflict     sticky overlap flag (only with STORE_SLOT_LAYOUT_CONFLICT_EN)
//   Optional feature macro: STORE_SLOT_LAYOUT_CONFLICT_EN.
package MSX;
  typedef enum logic [3:0] {
    CONFIG_NONE       = 4'd0,
    CONFIG_ROM        = 4'd1,
    CONFIG_RAM        = 4'd2,
    CONFIG_RAM_MAPPER = 4'd3,
    CONFIG_MIRROR     = 4'd4,
    CONFIG_ROM_MIRROR = 4'd5,
    CONFIG_IO_MIRROR  = 4'd6,
    CONFIG_IO         = 4'd7
  } config_typ_t;

  typedef struct packed {
    config_typ_t typ;
    logic [1:0]  slot;
    logic [1:0]  sub_slot;
    logic [1:0]  start_block;
    logic [3:0]  reference;
    logic [7:0]  block_count;
  } msx_config_t;
endpackage

module store_slot_layout #(
  parameter int MAX_CONFIG = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  MSX::msx_config_t   msx_config [MAX_CONFIG],
  store_slot_layout_if.slave bus
`ifdef STORE_SLOT_LAYOUT_CONFLICT_EN
  ,
  output logic               conflict
`endif
);
  localparam int CW = $clog2(MAX_CONFIG);
  localparam int EW = 1 + CW + 2;
  localparam logic [CW-1:0] LAST_CFG = CW'(MAX_CONFIG - 1);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FETCH, S_FILL, S_DONE} state_t;

  // Number of pages a record occupies; pages past page 3 are dropped, never wrapped.
  function automatic logic [2:0] fill_count(input MSX::msx_config_t rec);
    logic [2:0] room;
    room = 3'd4 - {1'b0, rec.start_block};
    if (rec.typ == MSX::CONFIG_NONE)            return 3'd0;
    else if (rec.typ == MSX::CONFIG_RAM_MAPPER) return room;
    else if (rec.block_count == 8'd0)           return 3'd0;
    else if (rec.block_count < {5'd0, room})    return rec.block_count[2:0];
    else                                        return room;
  endfunction

  // Mirror records point the decoder at the record they mirror.
  function automatic logic is_mirror(input MSX::config_typ_t t);
    return (t == MSX::CONFIG_MIRROR) || (t == MSX::CONFIG_ROM_MIRROR) ||
           (t == MSX::CONFIG_IO_MIRROR);
  endfunction

  logic [EW-1:0]    table_q [64];

  state_t           state_q, state_d;
  logic [5:0]       addr_q, addr_d;
  logic [CW-1:0]    cfg_q, cfg_d;
  logic [1:0]       i_q, i_d;
  logic [2:0]       fill_cnt_q, fill_cnt_d;
  logic [1:0]       cur_slot_q, cur_slot_d;
  logic [1:0]       cur_sub_q, cur_sub_d;
  logic [1:0]       cur_start_q, cur_start_d;
  logic [CW-1:0]    idx_q, idx_d;
  logic             layout_valid_q, layout_valid_d;
  logic             layout_done_q, layout_done_d;
  logic [3:0]       slot_expanded_q, slot_expanded_d;
  logic [EW-1:0]    rd_entry_q;
  logic             conflict_q, conflict_d;

  logic             we;
  logic [5:0]       waddr;
  logic [EW-1:0]    wdata;
  logic             advance;
  MSX::msx_config_t fetch_rec;
  logic [2:0]       fetch_cnt;

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    cfg_d           = cfg_q;
    i_d             = i_q;
    fill_cnt_d      = fill_cnt_q;
    cur_slot_d      = cur_slot_q;
    cur_sub_d       = cur_sub_q;
    cur_start_d     = cur_start_q;
    idx_d           = idx_q;
    layout_valid_d  = layout_valid_q;
    layout_done_d   = 1'b0;
    slot_expanded_d = slot_expanded_q;
    conflict_d      = conflict_q;
    we              = 1'b0;
    waddr           = addr_q;
    wdata           = '0;
    advance         = 1'b0;
    fetch_rec       = msx_config[cfg_q];
    fetch_cnt       = fill_count(fetch_rec);

    case (state_q)
      S_IDLE: begin
        if (bus.update_request) begin
          layout_valid_d  = 1'b0;
          slot_expanded_d = 4'd0;
          conflict_d      = 1'b0;
          addr_d          = 6'd0;
          state_d         = S_CLEAR;
        end
      end
      S_CLEAR: begin
        we     = 1'b1;
        waddr  = addr_q;
        addr_d = addr_q + 6'd1;
        if (addr_q == 6'd63) begin
          cfg_d   = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        cur_slot_d  = fetch_rec.slot;
        cur_sub_d   = fetch_rec.sub_slot;
        cur_start_d = fetch_rec.start_block;
        idx_d       = is_mirror(fetch_rec.typ) ? CW'(fetch_rec.reference) : cfg_q;
        fill_cnt_d  = fetch_cnt;
        i_d         = 2'd0;
        if (fetch_cnt == 3'd0) advance = 1'b1;
        else                   state_d = S_FILL;
      end
      S_FILL: begin
        we    = 1'b1;
        waddr = {cur_slot_q, cur_sub_q, cur_start_q + i_q};
        wdata = {1'b1, idx_q, i_q};
        if (cur_sub_q != 2'd0) slot_expanded_d[cur_slot_q] = 1'b1;
        // Target read combinationally so detection costs no extra cycle.
        if (table_q[waddr][EW-1]) conflict_d = 1'b1;
        i_d = i_q + 2'd1;
        if ({1'b0, i_q} == fill_cnt_q - 3'd1) advance = 1'b1;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (advance) begin
      if (cfg_q == LAST_CFG) begin
        layout_valid_d = 1'b1;
        layout_done_d  = 1'b1;
        state_d        = S_DONE;
      end else begin
        cfg_d   = cfg_q + 1'b1;
        state_d = S_FETCH;
      end
    end
  end

  // ---- control / status registers ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_IDLE;
      layout_valid_q  <= 1'b0;
      layout_done_q   <= 1'b0;
      slot_expanded_q <= 4'd0;
      conflict_q      <= 1'b0;
      rd_entry_q      <= '0;
    end else begin
      state_q         <= state_d;
      layout_valid_q  <= layout_valid_d;
      layout_done_q   <= layout_done_d;
      slot_expanded_q <= slot_expanded_d;
      conflict_q      <= conflict_d;
      rd_entry_q      <= table_q[{bus.rd_slot, bus.rd_sub, bus.rd_page}];
    end
  end

  // ---- walk counters and latched record (don't-care until the next build) ----
  always_ff @(posedge clk) begin
    addr_q      <= addr_d;
    cfg_q       <= cfg_d;
    i_q         <= i_d;
    fill_cnt_q  <= fill_cnt_d;
    cur_slot_q  <= cur_slot_d;
    cur_sub_q   <= cur_sub_d;
    cur_start_q <= cur_start_d;
    idx_q       <= idx_d;
  end

  // ---- layout table (contents survive reset; layout_valid qualifies them) ----
  always_ff @(posedge clk) begin
    if (we) table_q[waddr] <= wdata;
  end

  // Ack is only offered in IDLE and never while reset is held.
  assign bus.update_ack    = (state_q == S_IDLE) && bus.update_request && !reset;
  assign bus.layout_valid  = layout_valid_q;
  assign bus.layout_done   = layout_done_q;
  assign bus.slot_expanded = slot_expanded_q;
  assign bus.rd_entry      = rd_entry_q;

`ifdef STORE_SLOT_LAYOUT_CONFLICT_EN
  assign conflict = conflict_q;
`else
  logic unused_conflict;
  assign unused_conflict = conflict_q ^ conflict_d;
`endif
endmodule

// File: tb/tb_store_slot_layout.sv
module tb_store_slot_layout;
  import MSX::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  msx_config_t cfg [16];
  store_slot_layout_if #(.MAX_CONFIG(16)) bus ();
`ifdef STORE_SLOT_LAYOUT_CONFLICT_EN
  logic conflict;
`endif

  store_slot_layout #(.MAX_CONFIG(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .msx_config (cfg),
    .bus        (bus)
`ifdef STORE_SLOT_LAYOUT_CONFLICT_EN
    ,
    .conflict   (conflict)
`endif
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int         scen;
    logic [1:0] slot;
    logic [1:0] sub;
    logic [1:0] page;
    logic [6:0] exp;
  } vec_t;
  vec_t vecs [23];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the end, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic msx_config_t mk(input config_typ_t t, input logic [1:0] s,
                                     input logic [1:0] sb, input logic [1:0] st,
                                     input logic [3:0] r, input logic [7:0] n);
    msx_config_t c;
    c.typ = t; c.slot = s; c.sub_slot = sb; c.start_block = st;
    c.reference = r; c.block_count = n;
    return c;
  endfunction

  task automatic clear_cfgs();
    for (int k = 0; k < 16; k++) cfg[k] = mk(CONFIG_NONE, 2'd0, 2'd0, 2'd0, 4'd0, 8'd0);
  endtask

  task automatic set_vec(input int k, input int scen, input logic [1:0] s,
                         input logic [1:0] sb, input logic [1:0] p, input logic [6:0] e);
    vecs[k].scen = scen; vecs[k].slot = s; vecs[k].sub = sb; vecs[k].page = p; vecs[k].exp = e;
  endtask

  task automatic check_scen(input int scen);
    for (int k = 0; k < 23; k++) begin
      if (vecs[k].scen == scen) begin
        bus.rd_slot = vecs[k].slot;
        bus.rd_sub  = vecs[k].sub;
        bus.rd_page = vecs[k].page;
        step();
        check($sformatf("entry scen%0d [%0d][%0d][%0d]", scen, vecs[k].slot, vecs[k].sub,
                        vecs[k].page), {25'd0, bus.rd_entry}, {25'd0, vecs[k].exp});
      end
    end
  endtask

  task automatic request_build(input bit hold, output int a_cyc, output bit ok);
    bus.update_request = 1'b1;
    ok = 1'b0;
    a_cyc = 0;
    for (int k = 0; k < 400 && !ok; k++) begin
      #1;
      if (bus.update_ack) begin
        ok = 1'b1;
        a_cyc = cyc;
      end else begin
        step();
      end
    end
    step();
    if (!hold) bus.update_request = 1'b0;
  endtask

  task automatic wait_done(output int d_cyc, output bit ok);
    ok = 1'b0;
    d_cyc = 0;
    for (int k = 0; k < 400 && !ok; k++) begin
      if (bus.layout_done) begin
        ok = 1'b1;
        d_cyc = cyc;
      end else begin
        step();
      end
    end
  endtask

  task automatic do_build(input int scen, input int exp_lat, input logic [3:0] exp_xp);
    int a, d;
    bit ok;
    request_build(1'b0, a, ok);
    check($sformatf("scen%0d ack seen", scen), {31'd0, ok}, 32'd1);
    check($sformatf("scen%0d valid low after ack", scen), {31'd0, bus.layout_valid}, 32'd0);
    wait_done(d, ok);
    check($sformatf("scen%0d done seen", scen), {31'd0, ok}, 32'd1);
    check($sformatf("scen%0d latency", scen), d - a + 1, exp_lat);
    check($sformatf("scen%0d valid with done", scen), {31'd0, bus.layout_valid}, 32'd1);
    step();
    check($sformatf("scen%0d done single pulse", scen), {31'd0, bus.layout_done}, 32'd0);
    check($sformatf("scen%0d slot_expanded", scen), {28'd0, bus.slot_expanded}, {28'd0, exp_xp});
    check_scen(scen);
  endtask

  initial begin
    int a, d, d2;
    bit ok, early;

    // Expected table entries {valid, cfg_idx[3:0], page_offset[1:0]}
    set_vec( 0, 1, 2'd0, 2'd0, 2'd0, 7'h00);
    set_vec( 1, 1, 2'd3, 2'd3, 2'd3, 7'h00);
    set_vec( 2, 2, 2'd1, 2'd0, 2'd1, 7'h40);
    set_vec( 3, 2, 2'd1, 2'd0, 2'd2, 7'h41);
    set_vec( 4, 2, 2'd1, 2'd0, 2'd0, 7'h00);
    set_vec( 5, 2, 2'd1, 2'd0, 2'd3, 7'h00);
    set_vec( 6, 3, 2'd0, 2'd0, 2'd3, 7'h40);
    set_vec( 7, 3, 2'd0, 2'd0, 2'd0, 7'h00);
    set_vec( 8, 3, 2'd2, 2'd1, 2'd2, 7'h50);
    set_vec( 9, 3, 2'd2, 2'd1, 2'd3, 7'h51);
    set_vec(10, 3, 2'd2, 2'd1, 2'd1, 7'h00);
    set_vec(11, 3, 2'd1, 2'd0, 2'd1, 7'h00);
    set_vec(12, 4, 2'd3, 2'd2, 2'd0, 7'h54);
    set_vec(13, 4, 2'd3, 2'd2, 2'd1, 7'h00);
    set_vec(14, 4, 2'd0, 2'd0, 2'd0, 7'h00);
    set_vec(15, 5, 2'd2, 2'd0, 2'd0, 7'h44);
    set_vec(16, 5, 2'd2, 2'd0, 2'd1, 7'h45);
    set_vec(17, 5, 2'd3, 2'd2, 2'd0, 7'h00);
    set_vec(18, 6, 2'd1, 2'd3, 2'd0, 7'h40);
    set_vec(19, 6, 2'd1, 2'd3, 2'd1, 7'h41);
    set_vec(20, 6, 2'd1, 2'd3, 2'd2, 7'h42);
    set_vec(21, 6, 2'd1, 2'd3, 2'd3, 7'h43);
    set_vec(22, 6, 2'd2, 2'd0, 2'd0, 7'h00);

    clear_cfgs();
    bus.update_request = 1'b1;
    bus.rd_slot = 2'd0;
    bus.rd_sub  = 2'd0;
    bus.rd_page = 2'd0;

    // Reset values, with a request pending that must not be acked under reset
    reset = 1'b1;
    step();
    step();
    check("reset ack", {31'd0, bus.update_ack}, 32'd0);
    check("reset valid", {31'd0, bus.layout_valid}, 32'd0);
    check("reset done", {31'd0, bus.layout_done}, 32'd0);
    check("reset slot_expanded", {28'd0, bus.slot_expanded}, 32'd0);
    check("reset rd_entry", {25'd0, bus.rd_entry}, 32'd0);
`ifdef STORE_SLOT_LAYOUT_CONFLICT_EN
    check("reset conflict", {31'd0, conflict}, 32'd0);
`endif
    bus.update_request = 1'b0;
    step();
    reset = 1'b0;
    step();
    check("idle no ack without request", {31'd0, bus.update_ack}, 32'd0);

    // Empty configs
    do_build(1, 82, 4'b0000);

    // Single ROM
    cfg[0] = mk(CONFIG_ROM, 2'd1, 2'd0, 2'd1, 4'd0, 8'd2);
    do_build(2, 84, 4'b0000);

    // Clipping and RAM mapper ignoring block_count
    clear_cfgs();
    cfg[0] = mk(CONFIG_ROM, 2'd0, 2'd0, 2'd3, 4'd0, 8'd8);
    cfg[4] = mk(CONFIG_RAM_MAPPER, 2'd2, 2'd1, 2'd2, 4'd0, 8'd0);
    do_build(3, 85, 4'b0100);

    // Mirror and expansion; zero-count ROM writes nothing
    clear_cfgs();
    cfg[1] = mk(CONFIG_ROM, 2'd0, 2'd0, 2'd0, 4'd0, 8'd0);
    cfg[2] = mk(CONFIG_MIRROR, 2'd3, 2'd2, 2'd0, 4'd5, 8'd1);
    do_build(4, 83, 4'b1000);
`ifdef STORE_SLOT_LAYOUT_CONFLICT_EN
    check("no overlap conflict", {31'd0, conflict}, 32'd0);
`endif

    // Overlap, last writer wins
    clear_cfgs();
    cfg[0] = mk(CONFIG_RAM, 2'd2, 2'd0, 2'd0, 4'd0, 8'd1);
    cfg[1] = mk(CONFIG_ROM, 2'd2, 2'd0, 2'd0, 4'd0, 8'd2);
    do_build(5, 85, 4'b0000);
`ifdef STORE_SLOT_LAYOUT_CONFLICT_EN
    check("overlap conflict", {31'd0, conflict}, 32'd1);
`endif

    // Request raised again 10 cycles into a build
    request_build(1'b0, a, ok);
    check("held first ack", {31'd0, ok}, 32'd1);
    for (int k = 0; k < 20 && cyc < a + 10; k++) step();
    bus.update_request = 1'b1;
    early = 1'b0;
    ok = 1'b0;
    d = 0;
    for (int k = 0; k < 400 && !ok; k++) begin
      #1;
      if (bus.layout_done) begin
        ok = 1'b1;
        d = cyc;
      end else begin
        if (bus.update_ack) early = 1'b1;
        step();
      end
    end
    check("held no ack during build", {31'd0, early}, 32'd0);
    check("held first done", {31'd0, ok}, 32'd1);
    check("held first latency", d - a + 1, 85);
    step();
    check("held ack after done", {31'd0, bus.update_ack}, 32'd1);
    step();
    bus.update_request = 1'b0;
    check("held valid drops", {31'd0, bus.layout_valid}, 32'd0);
`ifdef STORE_SLOT_LAYOUT_CONFLICT_EN
    check("conflict cleared at ack", {31'd0, conflict}, 32'd0);
`endif
    wait_done(d2, ok);
    check("held second done", {31'd0, ok}, 32'd1);
    check("held second latency", d2 - (d + 1) + 1, 85);
    check("held second valid", {31'd0, bus.layout_valid}, 32'd1);
    step();
    check_scen(5);

    // Reset for one cycle during FILL with the request still held
    clear_cfgs();
    cfg[0] = mk(CONFIG_ROM, 2'd1, 2'd3, 2'd0, 4'd0, 8'd4);
    request_build(1'b1, a, ok);
    check("rst ack", {31'd0, ok}, 32'd1);
    for (int k = 0; k < 200 && cyc < a + 67; k++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    check("rst ack after reset", {31'd0, bus.update_ack}, 32'd1);
    check("rst valid", {31'd0, bus.layout_valid}, 32'd0);
    check("rst done", {31'd0, bus.layout_done}, 32'd0);
    check("rst slot_expanded", {28'd0, bus.slot_expanded}, 32'd0);
    check("rst rd_entry", {25'd0, bus.rd_entry}, 32'd0);
`ifdef STORE_SLOT_LAYOUT_CONFLICT_EN
    check("rst conflict", {31'd0, conflict}, 32'd0);
`endif
    a = cyc;
    step();
    bus.update_request = 1'b0;
    wait_done(d, ok);
    check("rst rebuild done", {31'd0, ok}, 32'd1);
    check("rst rebuild latency", d - a + 1, 86);
    check("rst rebuild valid", {31'd0, bus.layout_valid}, 32'd1);
    step();
    check("rst rebuild slot_expanded", {28'd0, bus.slot_expanded}, 32'd2);
    check_scen(6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/store_slot_layout.md
# store_slot_layout

Downstream consumer of the parsed MSX configuration records. When the parser raises `update_request`, this block walks all `MAX_CONFIG` records and builds a 64-entry slot layout table indexed by primary slot, sub-slot and 16 KB page. It also derives the per-slot expansion flags. The slot decoder reads the table through a registered read port and uses it to route CPU accesses to the owning config record.

## Interface

**Parameters**
- `MAX_CONFIG`, default 16: number of config records; index width `CW = $clog2(MAX_CONFIG)` (4 at default).

**Ports** (clock and reset first)
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `msx_config` in `MSX::msx_config_t [MAX_CONFIG]`: parsed records.
  - Used fields: `slot[1:0]`, `sub_slot[1:0]`, `start_block[1:0]`, `typ`, `reference[3:0]`, `block_count[7:0]`.
- `update_request` in 1: level from the parser; held until acked.
- `update_ack` out 1: one-cycle pulse accepting the request.
- `layout_valid` out 1: table is complete and coherent.
- `layout_done` out 1: one-cycle pulse when a build finishes.
- `slot_expanded` out 4: bit n set if any live record in slot n uses `sub_slot != 0`.
- `rd_slot` in 2, `rd_sub` in 2, `rd_page` in 2: read address.
- `rd_entry` out `1+CW+2`: registered entry `{valid, cfg_idx, page_offset}`.
- `conflict` out 1: sticky overlap flag; present only with `STORE_SLOT_LAYOUT_CONFLICT_EN`.

## Operation

**State machine:** IDLE, CLEAR, FETCH, FILL, DONE.

- **IDLE**
  - If `update_request`: pulse `update_ack`, drop `layout_valid`, clear `slot_expanded` and `conflict`, reset the address counter to 0, go to CLEAR.
  - A request is acked only in IDLE. A request raised during a build is taken on the first IDLE cycle after DONE.
- **CLEAR**
  - Write 0 to the entry at the counter; increment it.
  - After entry 63 is written: set `cfg = 0`, go to FETCH.
- **FETCH**
  - Latch record `cfg`.
  - Set `fill_cnt`:
    - `typ == CONFIG_NONE` or `block_count == 0`: 0.
    - `CONFIG_RAM_MAPPER`: `4 - start_block`, regardless of `block_count`.
    - Otherwise: `min(block_count, 4 - start_block)`. Pages beyond page 3 are clipped and never wrap to page 0.
  - If `fill_cnt == 0`: advance `cfg`. Otherwise go to FILL with `i = 0`.
- **FILL**, one write per cycle, for `i` in `0..fill_cnt-1`:
  - Address: `{slot, sub_slot, start_block + i}`.
  - Entry: `{1, idx, i[1:0]}`.
    - `idx = reference` for `CONFIG_MIRROR`, `CONFIG_ROM_MIRROR` and `CONFIG_IO_MIRROR`.
    - `idx = cfg` otherwise.
  - If `sub_slot != 0`, set `slot_expanded[slot]`.
  - After the last write, advance `cfg`.
- **Advancing `cfg`:** if `cfg == MAX_CONFIG-1`, go to DONE; otherwise increment `cfg` and go to FETCH.
- **Overlaps:** a later record overwrites an earlier one (last-writer-wins).
- **DONE:** set `layout_valid`, pulse `layout_done`, go to IDLE.
- **Read port:** `rd_entry` is updated every cycle from the table, regardless of state. It is meaningful only while `layout_valid = 1`.

## Timing

- **Reset values:** `update_ack`=0, `layout_valid`=0, `layout_done`=0, `slot_expanded`=0, `rd_entry`=0, `conflict`=0, state=IDLE.
- **Table contents on reset:** not cleared. Software relies on `layout_valid`.
- **Reset mid-build:** abort; back to IDLE with `layout_valid=0`. A still-held `update_request` is acked on the cycle after reset deasserts.
- **Build latency:** `update_ack` cycle + 64 CLEAR + `MAX_CONFIG` FETCH + Σ`fill_cnt` FILL + 1 DONE.
  - Empty configs at `MAX_CONFIG=16`: 82 cycles from the ack to `layout_done`.
- **`layout_valid`:** rises in the same cycle as the `layout_done` pulse.
- **Read latency:** 1 cycle from address to `rd_entry`.
- **Read/write collision:** a read of an entry written in the same cycle returns the old value.
- **`msx_config` stability:** must be stable from ack to DONE. The parser guarantees this because it only changes records before raising the request.

## Configuration

- **`STORE_SLOT_LAYOUT_CONFLICT_EN` defined:**
  - In FILL, if the target entry already has `valid=1`, set sticky `conflict`.
  - `conflict` clears only at the next ack or on reset.
  - Detection needs a read-before-write of the table, implemented as an internal combinational read of the target address. FILL throughput stays at 1 write per cycle.
- **Not defined:** the `conflict` port and its logic are absent; overlaps silently overwrite.

## Test plan

- **Single ROM:** record 0 = ROM, slot 1, sub 0, start 1, count 2; others NONE.
  - Entries [1][0][1]=`{1,0,0}` and [1][0][2]=`{1,0,1}`; all others 0.
  - `layout_done` 84 cycles after `update_ack`.
- **Clipping:** start 3, count 8.
  - Only page 3 written, `{1,idx,0}`; page 0 stays 0.
  - RAM_MAPPER with start 2, count 0 writes pages 2 and 3.
- **Mirror and expansion:** record 2 = MIRROR, reference 5, slot 3, sub 2, start 0, count 1.
  - Entry [3][2][0]=`{1,5,0}`; `slot_expanded=4'b1000`.
- **Overlap:** records 0 and 1 both map slot 2, sub 0, page 0.
  - Entry holds cfg_idx 1.
  - `conflict`=1 with the macro defined; port absent without it.
- **Held request:** raise `update_request` again 10 cycles into a build.
  - No ack until the first build's `layout_done`.
  - Then ack on the next cycle and `layout_valid` drops.
- **Reset mid-FILL:** assert `reset` for 1 cycle during FILL.
  - All outputs return to reset values; with the request held, ack on the next cycle and the rebuild completes correctly.
